// File: rtl/cmd_multiplexer_pkg.sv
// Shared types and constants for the DRAM command multiplexer and its round-robin arbiter.
package cmd_multiplexer_pkg;

  localparam int CFG_W = 8;

  typedef enum logic [2:0] {
    ST_READ    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RTW     = 3'd2,
    ST_WTR     = 3'd3,
    ST_REFRESH = 3'd4
  } mux_state_e;

  // Command strobes packed as {ras, cas, we}, active-high.
  typedef enum logic [2:0] {
    CMD_NOP = 3'b000,
    CMD_ACT = 3'b100,
    CMD_PRE = 3'b101,
    CMD_RD  = 3'b010,
    CMD_WR  = 3'b011,
    CMD_REF = 3'b110
  } dram_cmd_e;

  function automatic logic [CFG_W-1:0] cfg_load(input logic [CFG_W-1:0] cfg);
    return (cfg == '0) ? '0 : cfg - CFG_W'(1);
  endfunction

endpackage

// File: rtl/cmd_multiplexer_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping mod N.
module cmd_multiplexer_rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  always_comb begin
    int idx;
    idx         = 0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o    = 1'b1;
        gnt_o[idx]     = 1'b1;
        gnt_idx_o      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cmd_multiplexer.sv
// Merges bank-machine and refresher command streams onto the PHY command bus.
// Optional statistics counters are built when CMD_MUX_STATS_EN is defined.
module cmd_multiplexer
  import cmd_multiplexer_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_W    = 17,
  parameter int BA_W      = 3
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_BANKS-1:0]      bm_cmd_valid,
  output logic [NUM_BANKS-1:0]      bm_cmd_ready,
  input  logic [NUM_BANKS*ADDR_W-1:0] bm_cmd_a,
  input  logic [NUM_BANKS*BA_W-1:0] bm_cmd_ba,
  input  logic [NUM_BANKS-1:0]      bm_cmd_cas,
  input  logic [NUM_BANKS-1:0]      bm_cmd_ras,
  input  logic [NUM_BANKS-1:0]      bm_cmd_we,
  input  logic [NUM_BANKS-1:0]      bm_cmd_is_cmd,
  input  logic [NUM_BANKS-1:0]      bm_cmd_is_read,
  input  logic [NUM_BANKS-1:0]      bm_cmd_is_write,
  input  logic [NUM_BANKS-1:0]      bm_refresh_gnt,
  input  logic                      refresh_req,
  input  logic                      ref_valid,
  output logic                      ref_ready,
  input  logic [ADDR_W-1:0]         ref_a,
  input  logic [BA_W-1:0]           ref_ba,
  input  logic                      ref_cas,
  input  logic                      ref_ras,
  input  logic                      ref_we,
  input  logic [CFG_W-1:0]          tCCD_cfg,
  input  logic [CFG_W-1:0]          tRTW_cfg,
  input  logic [CFG_W-1:0]          tWTR_cfg,
  output logic                      phy_cs,
  output logic                      phy_ras,
  output logic                      phy_cas,
  output logic                      phy_we,
  output logic [ADDR_W-1:0]         phy_address,
  output logic [BA_W-1:0]           phy_bank,
  output logic                      phy_rddata_en,
  output logic                      phy_wrdata_en
`ifdef CMD_MUX_STATS_EN
  ,
  output logic [31:0]               stat_rd_cnt,
  output logic [31:0]               stat_wr_cnt,
  output logic [31:0]               stat_turn_cnt
`endif
);

  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  mux_state_e             state_q;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [CFG_W-1:0]       ccd_cnt_q, ccd_cnt_d, turn_cnt_q;
  logic                   ccd_ok, gnt_any, bank_accept, ref_accept, issue;
  logic                   refresh_go, opp_pending, turn_go;
  logic [NUM_BANKS-1:0]   rd_ok, wr_ok, non_cas, elig, gnt;
  logic [2:0]             sel_cmd;
  logic [ADDR_W-1:0]      sel_a;
  logic [BA_W-1:0]        sel_ba;
  logic                   sel_rd, sel_wr;
  logic                   phy_cs_q, phy_rd_q, phy_wr_q;
  logic [2:0]             phy_cmd_q;
  logic [ADDR_W-1:0]      phy_addr_q;
  logic [BA_W-1:0]        phy_bank_q;

  assign ccd_ok  = (ccd_cnt_q == '0);
  assign non_cas = bm_cmd_valid & bm_cmd_is_cmd & ~bm_cmd_cas;
  assign rd_ok   = bm_cmd_valid & bm_cmd_is_read  & {NUM_BANKS{ccd_ok}};
  assign wr_ok   = bm_cmd_valid & bm_cmd_is_write & {NUM_BANKS{ccd_ok}};

  // Non-CAS commands (ACT/PRE) may issue regardless of the current data direction.
  always_comb begin
    case (state_q)
      ST_READ:  elig = rd_ok | non_cas;
      ST_WRITE: elig = wr_ok | non_cas;
      default:  elig = '0;
    endcase
  end

  cmd_multiplexer_rr_arbiter #(
    .N     (NUM_BANKS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i       (elig),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_any)
  );

  assign bank_accept  = gnt_any;
  assign ref_accept   = !sys_rst && (state_q == ST_REFRESH) && refresh_req && ref_valid;
  assign issue        = bank_accept || ref_accept;
  assign bm_cmd_ready = sys_rst ? '0 : gnt;
  assign ref_ready    = ref_accept;

  assign refresh_go  = refresh_req && (&bm_refresh_gnt);
  assign opp_pending = (state_q == ST_WRITE) ? |(bm_cmd_valid & bm_cmd_is_read)
                                             : |(bm_cmd_valid & bm_cmd_is_write);
  assign turn_go     = ((state_q == ST_READ) || (state_q == ST_WRITE)) && !refresh_go &&
                       !bank_accept && opp_pending && ccd_ok;

  always_comb begin
    sel_cmd = CMD_NOP;
    sel_a   = '0;
    sel_ba  = '0;
    sel_rd  = 1'b0;
    sel_wr  = 1'b0;
    if (bank_accept) begin
      sel_cmd = {bm_cmd_ras[gnt_idx], bm_cmd_cas[gnt_idx], bm_cmd_we[gnt_idx]};
      sel_a   = bm_cmd_a[gnt_idx*ADDR_W +: ADDR_W];
      sel_ba  = bm_cmd_ba[gnt_idx*BA_W +: BA_W];
      sel_rd  = bm_cmd_is_read[gnt_idx];
      sel_wr  = bm_cmd_is_write[gnt_idx];
    end else if (ref_accept) begin
      sel_cmd = {ref_ras, ref_cas, ref_we};
      sel_a   = ref_a;
      sel_ba  = ref_ba;
    end
  end

  always_comb begin
    ccd_cnt_d = ccd_cnt_q;
    if (bank_accept && (sel_rd || sel_wr)) ccd_cnt_d = cfg_load(tCCD_cfg);
    else if (ccd_cnt_q != '0)              ccd_cnt_d = ccd_cnt_q - CFG_W'(1);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (bank_accept)
      rr_ptr_d = (gnt_idx == IDX_W'(NUM_BANKS - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  // Refresh entry outranks a direction switch; a bank grant in the same cycle still issues.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_READ;
      rr_ptr_q   <= '0;
      ccd_cnt_q  <= '0;
      turn_cnt_q <= '0;
      phy_cs_q   <= 1'b0;
      phy_cmd_q  <= CMD_NOP;
      phy_addr_q <= '0;
      phy_bank_q <= '0;
      phy_rd_q   <= 1'b0;
      phy_wr_q   <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      ccd_cnt_q <= ccd_cnt_d;
      phy_cs_q  <= issue;
      phy_cmd_q <= sel_cmd;
      phy_rd_q  <= sel_rd;
      phy_wr_q  <= sel_wr;
      if (issue) begin
        phy_addr_q <= sel_a;
        phy_bank_q <= sel_ba;
      end
      case (state_q)
        ST_READ: begin
          if (refresh_go) state_q <= ST_REFRESH;
          else if (turn_go) begin
            state_q    <= ST_RTW;
            turn_cnt_q <= cfg_load(tRTW_cfg);
          end
        end
        ST_WRITE: begin
          if (refresh_go) state_q <= ST_REFRESH;
          else if (turn_go) begin
            state_q    <= ST_WTR;
            turn_cnt_q <= cfg_load(tWTR_cfg);
          end
        end
        ST_RTW: begin
          if (turn_cnt_q == '0) state_q <= ST_WRITE;
          else                  turn_cnt_q <= turn_cnt_q - CFG_W'(1);
        end
        ST_WTR: begin
          if (turn_cnt_q == '0) state_q <= ST_READ;
          else                  turn_cnt_q <= turn_cnt_q - CFG_W'(1);
        end
        ST_REFRESH: begin
          if (!refresh_req || ref_accept) state_q <= ST_READ;
        end
        default: state_q <= ST_READ;
      endcase
    end
  end

  assign phy_cs        = phy_cs_q;
  assign phy_ras       = phy_cmd_q[2];
  assign phy_cas       = phy_cmd_q[1];
  assign phy_we        = phy_cmd_q[0];
  assign phy_address   = phy_addr_q;
  assign phy_bank      = phy_bank_q;
  assign phy_rddata_en = phy_rd_q;
  assign phy_wrdata_en = phy_wr_q;

`ifdef CMD_MUX_STATS_EN
  logic [31:0] stat_rd_q, stat_wr_q, stat_turn_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stat_rd_q   <= '0;
      stat_wr_q   <= '0;
      stat_turn_q <= '0;
    end else begin
      if (bank_accept && sel_rd && (stat_rd_q != '1)) stat_rd_q   <= stat_rd_q + 32'd1;
      if (bank_accept && sel_wr && (stat_wr_q != '1)) stat_wr_q   <= stat_wr_q + 32'd1;
      if (turn_go && (stat_turn_q != '1))             stat_turn_q <= stat_turn_q + 32'd1;
    end
  end

  assign stat_rd_cnt   = stat_rd_q;
  assign stat_wr_cnt   = stat_wr_q;
  assign stat_turn_cnt = stat_turn_q;
`endif

endmodule

// File: tb/tb_cmd_multiplexer.sv
// Bench for cmd_multiplexer: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_cmd_multiplexer;

  localparam int NB = 8;
  localparam int AW = 17;
  localparam int BW = 3;
  localparam int KIND_NONE = 0, KIND_RD = 1, KIND_WR = 2, KIND_ACT = 3, KIND_PRE = 4;

  logic sysClk = 1'b0;
  logic sysRst;
  logic [NB-1:0] bmValid, bmReady, bmCas, bmRas, bmWe, bmIsCmd, bmIsRead, bmIsWrite, bmRefreshGnt;
  logic [NB*AW-1:0] bmA;
  logic [NB*BW-1:0] bmBa;
  logic [AW-1:0] bankAddr [NB];
  logic [BW-1:0] bankBa [NB];
  logic refreshReq, refValid, refReady, refCas, refRas, refWe;
  logic [AW-1:0] refA;
  logic [BW-1:0] refBa;
  logic [7:0] tCcd, tRtw, tWtr;
  logic phyCs, phyRas, phyCas, phyWe, phyRd, phyWr;
  logic [AW-1:0] phyAddr;
  logic [BW-1:0] phyBank;

  int vectors = 0;
  int miscompares = 0;

  // Model state: data direction, turnaround countdown, refresh window, pointer, CAS spacing.
  int ptr, ccdLeft, turnLeft;
  bit dirWrite, turning, inRefresh;
  bit expCs, expRas, expCas, expWe, expRd, expWr;
  logic [AW-1:0] expAddr;
  logic [BW-1:0] expBank;
  bit consume;
  int cycle;

  always #5 sysClk = ~sysClk;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bmA[i*AW +: AW] = bankAddr[i];
      bmBa[i*BW +: BW] = bankBa[i];
    end
  end

  cmd_multiplexer #(.NUM_BANKS(NB), .ADDR_W(AW), .BA_W(BW)) dut (
    .sys_clk(sysClk), .sys_rst(sysRst),
    .bm_cmd_valid(bmValid), .bm_cmd_ready(bmReady), .bm_cmd_a(bmA), .bm_cmd_ba(bmBa),
    .bm_cmd_cas(bmCas), .bm_cmd_ras(bmRas), .bm_cmd_we(bmWe),
    .bm_cmd_is_cmd(bmIsCmd), .bm_cmd_is_read(bmIsRead), .bm_cmd_is_write(bmIsWrite),
    .bm_refresh_gnt(bmRefreshGnt), .refresh_req(refreshReq),
    .ref_valid(refValid), .ref_ready(refReady), .ref_a(refA), .ref_ba(refBa),
    .ref_cas(refCas), .ref_ras(refRas), .ref_we(refWe),
    .tCCD_cfg(tCcd), .tRTW_cfg(tRtw), .tWTR_cfg(tWtr),
    .phy_cs(phyCs), .phy_ras(phyRas), .phy_cas(phyCas), .phy_we(phyWe),
    .phy_address(phyAddr), .phy_bank(phyBank),
    .phy_rddata_en(phyRd), .phy_wrdata_en(phyWr)
  );

  function automatic int minusOne(input int x);
    return (x == 0) ? 0 : x - 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setBank(input int i, input int kind);
    bmValid[i]   = (kind != KIND_NONE);
    bmIsRead[i]  = (kind == KIND_RD);
    bmIsWrite[i] = (kind == KIND_WR);
    bmIsCmd[i]   = (kind == KIND_ACT) || (kind == KIND_PRE);
    bmCas[i]     = (kind == KIND_RD) || (kind == KIND_WR);
    bmRas[i]     = (kind == KIND_ACT) || (kind == KIND_PRE);
    bmWe[i]      = (kind == KIND_WR) || (kind == KIND_PRE);
    bankAddr[i]  = AW'($urandom);
    bankBa[i]    = BW'($urandom);
  endtask

  task automatic clearAll();
    for (int i = 0; i < NB; i++) setBank(i, KIND_NONE);
    bmRefreshGnt = '0;
    refreshReq = 1'b0;
    refValid = 1'b0;
    refRas = 1'b1; refCas = 1'b1; refWe = 1'b0;
    refA = AW'($urandom);
    refBa = BW'($urandom);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NB; i++)
      setBank(i, ($urandom_range(0, 99) < 45) ? int'($urandom_range(1, 4)) : KIND_NONE);
    refreshReq   = ($urandom_range(0, 99) < 15);
    bmRefreshGnt = ($urandom_range(0, 3) != 0) ? '1 : NB'($urandom);
    refValid     = $urandom_range(0, 1);
    refRas = $urandom_range(0, 1); refCas = $urandom_range(0, 1); refWe = $urandom_range(0, 1);
    refA = AW'($urandom);
    refBa = BW'($urandom);
  endtask

  task automatic modelReset();
    ptr = 0; ccdLeft = 0; turnLeft = 0;
    dirWrite = 0; turning = 0; inRefresh = 0;
    expCs = 0; expRas = 0; expCas = 0; expWe = 0; expRd = 0; expWr = 0;
    expAddr = '0; expBank = '0;
  endtask

  function automatic int modelGrant();
    int i;
    if (inRefresh || turning) return -1;
    for (int off = 0; off < NB; off++) begin
      i = (ptr + off) % NB;
      if (bmValid[i] && ((((dirWrite ? bmIsWrite[i] : bmIsRead[i]) == 1'b1) && ccdLeft == 0) ||
                         (bmIsCmd[i] && !bmCas[i])))
        return i;
    end
    return -1;
  endfunction

  task automatic modelAdvance(input int g, input bit refAcc);
    bit ccdOkNow, anyOpp;
    ccdOkNow = (ccdLeft == 0);
    anyOpp = 0;
    for (int i = 0; i < NB; i++)
      if (bmValid[i] && (dirWrite ? bmIsRead[i] : bmIsWrite[i])) anyOpp = 1;
    if (g >= 0) begin
      expCs = 1; expRas = bmRas[g]; expCas = bmCas[g]; expWe = bmWe[g];
      expAddr = bankAddr[g]; expBank = bankBa[g];
      expRd = bmIsRead[g]; expWr = bmIsWrite[g];
    end else if (refAcc) begin
      expCs = 1; expRas = refRas; expCas = refCas; expWe = refWe;
      expAddr = refA; expBank = refBa; expRd = 0; expWr = 0;
    end else begin
      expCs = 0; expRas = 0; expCas = 0; expWe = 0; expRd = 0; expWr = 0;
    end
    if (g >= 0 && (bmIsRead[g] || bmIsWrite[g])) ccdLeft = minusOne(int'(tCcd));
    else if (ccdLeft > 0) ccdLeft--;
    if (g >= 0) ptr = (g + 1) % NB;
    if (inRefresh) begin
      if (!refreshReq || refAcc) begin inRefresh = 0; dirWrite = 0; end
    end else if (turning) begin
      if (turnLeft == 0) begin turning = 0; dirWrite = !dirWrite; end
      else turnLeft--;
    end else if (refreshReq && (&bmRefreshGnt)) begin
      inRefresh = 1;
    end else if (g < 0 && anyOpp && ccdOkNow) begin
      turning = 1;
      turnLeft = minusOne(dirWrite ? int'(tWtr) : int'(tRtw));
    end
  endtask

  task automatic checkPhy();
    checkOutput("phyCs", phyCs, expCs);
    checkOutput("phyRas", phyRas, expRas);
    checkOutput("phyCas", phyCas, expCas);
    checkOutput("phyWe", phyWe, expWe);
    checkOutput("phyAddr", phyAddr, expAddr);
    checkOutput("phyBank", phyBank, expBank);
    checkOutput("phyRddataEn", phyRd, expRd);
    checkOutput("phyWrdataEn", phyWr, expWr);
  endtask

  task automatic runCycle();
    int g;
    bit refAcc;
    #1;
    g = modelGrant();
    refAcc = inRefresh && refreshReq && refValid;
    checkOutput("bmReady", bmReady, (g >= 0) ? (32'd1 << g) : 32'd0);
    checkOutput("refReady", refReady, refAcc);
    modelAdvance(g, refAcc);
    @(posedge sysClk);
    #1;
    cycle++;
    if (consume && g >= 0) setBank(g, KIND_NONE);
    checkPhy();
  endtask

  task automatic checkResetState();
    modelReset();
    checkPhy();
    checkOutput("rstBmReady", bmReady, 32'd0);
    checkOutput("rstRefReady", refReady, 32'd0);
  endtask

  initial begin
    int lastCas;
    cycle = 0;
    consume = 1;
    tCcd = 8'd1; tRtw = 8'd1; tWtr = 8'd1;
    sysRst = 1'b1;
    clearAll();
    repeat (2) @(posedge sysClk);
    #1;
    checkResetState();
    sysRst = 1'b0;

    $display("[TB] reads on banks 0,3,5 with tCCD=1");
    setBank(0, KIND_RD); setBank(3, KIND_RD); setBank(5, KIND_RD);
    repeat (3) runCycle();
    setBank(6, KIND_RD); setBank(2, KIND_RD);
    repeat (3) runCycle();

    $display("[TB] bank 2 streaming reads with tCCD=4");
    consume = 0;
    tCcd = 8'd4;
    setBank(2, KIND_RD);
    lastCas = -1;
    repeat (14) begin
      runCycle();
      if (phyCas === 1'b1) begin
        if (lastCas >= 0) checkOutput("ccdSpacing", cycle - lastCas, 4);
        lastCas = cycle;
      end
    end
    consume = 1;
    setBank(2, KIND_NONE);
    tCcd = 8'd1;
    repeat (4) runCycle();

    $display("[TB] read-to-write turnaround with tRTW=3");
    tRtw = 8'd3;
    setBank(1, KIND_WR);
    repeat (8) runCycle();

    $display("[TB] ACT on bank 4 while in write direction");
    setBank(4, KIND_ACT);
    repeat (2) runCycle();

    $display("[TB] refresh handshake");
    refreshReq = 1'b1; bmRefreshGnt = '1; refValid = 1'b1;
    repeat (2) runCycle();
    refreshReq = 1'b0; refValid = 1'b0;
    setBank(0, KIND_RD);
    repeat (2) runCycle();

    $display("[TB] refresh abandoned, and bank grant coinciding with refresh entry");
    refreshReq = 1'b1; bmRefreshGnt = '1;
    setBank(3, KIND_RD);
    repeat (2) runCycle();
    refreshReq = 1'b0;
    repeat (2) runCycle();

    $display("[TB] randomized traffic");
    consume = 0;
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0) begin
        tCcd = 8'($urandom_range(0, 4));
        tRtw = 8'($urandom_range(0, 4));
        tWtr = 8'($urandom_range(0, 4));
      end
      applyStimulus();
      runCycle();
    end

    $display("[TB] asynchronous reset mid-command");
    clearAll();
    consume = 1;
    tCcd = 8'd1;
    repeat (3) runCycle();
    setBank(5, KIND_RD);
    runCycle();
    setBank(1, KIND_RD); setBank(7, KIND_RD);
    sysRst = 1'b1;
    #1;
    checkResetState();
    @(posedge sysClk);
    #2;
    sysRst = 1'b0;
    repeat (4) runCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
